// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared across pipeline stages and the W-stage register layout.
package cpu_pkg;
    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_MEM = 2'd1;
    localparam logic [1:0] WDSEL_PC8 = 2'd2;
    localparam logic [1:0] WDSEL_MDU = 2'd3;
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  a3;
        logic [1:0]  wdsel;
        logic [31:0] alu;
        logic [31:0] mdu;
        logic [31:0] rdata;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
    } w_reg_t;
endpackage

// File: rtl/load_ext.sv
// load_ext: picks the addressed byte/halfword from an aligned memory word and extends it.
module load_ext
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] ext
);
    logic [15:0] half;
    logic [7:0]  bval;
    always_comb begin
        half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        bval = rdata[8*addr_lo +: 8];
        ext  = ld_type == LD_LH  ? {{16{half[15]}}, half} :
               ld_type == LD_LHU ? {16'd0, half} :
               ld_type == LD_LB  ? {{24{bval[7]}}, bval} :
               ld_type == LD_LBU ? {24'd0, bval} : rdata;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register, write-back mux and retire counter.
// Define WB_TRACE_EN to print a judge-format trace line for every committed GRF write.
module wb_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic             m_we,
    input  logic [4:0]       m_a3,
    input  logic [1:0]       m_wdsel,
    input  logic [31:0]      m_alu,
    input  logic [31:0]      m_mdu,
    input  logic [31:0]      m_dm_rdata,
    input  logic [2:0]       m_ld_type,
    output logic             grf_we,
    output logic [4:0]       grf_a3,
    output logic [31:0]      grf_wd,
    output logic [31:0]      grf_pc,
    output logic             w_valid,
    output logic [CNT_W-1:0] retire_cnt
);
    w_reg_t      w, bubble;
    logic [31:0] ext, sel;
    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end
    always_ff @(posedge clk) begin
        if (reset || flush_i)
            w <= bubble;
        else if (!stall_i)
            w <= '{valid: m_valid, pc: m_pc, we: m_we, a3: m_a3, wdsel: m_wdsel, alu: m_alu,
                   mdu: m_mdu, rdata: m_dm_rdata, ld_type: m_ld_type, addr_lo: m_alu[1:0]};
    end
    // A flush in the same cycle still retires the instruction leaving W.
    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt <= '0;
        else if (w.valid && !stall_i)
            retire_cnt <= retire_cnt + CNT_W'(1);
    end
    load_ext u_load_ext (
        .rdata  (w.rdata),
        .addr_lo(w.addr_lo),
        .ld_type(w.ld_type),
        .ext    (ext)
    );
    // Write data and address are zeroed when not writing so forwarding never matches $0.
    always_comb begin
        sel    = w.wdsel == WDSEL_MEM ? ext :
                 w.wdsel == WDSEL_PC8 ? w.pc + 32'd8 :
                 w.wdsel == WDSEL_MDU ? w.mdu : w.alu;
        grf_we = w.valid && w.we && (w.a3 != 5'd0);
        grf_a3 = grf_we ? w.a3 : 5'd0;
        grf_wd = grf_we ? sel : 32'd0;
    end
    assign grf_pc  = w.pc;
    assign w_valid = w.valid;
`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (grf_we && !stall_i && !reset)
            $display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wd);
    end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, directed stall/flush/reset/wrap sequences and random traffic vs. a reference model.
module tb_wb_stage;
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  a3;
        logic [1:0]  wdsel;
        logic [31:0] alu;
        logic [31:0] mdu;
        logic [31:0] rdata;
        logic [2:0]  ld;
    } instr_t;
    typedef struct {
        instr_t      i;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall_i, flush_i, m_valid, m_we;
    logic [31:0] m_pc, m_alu, m_mdu, m_dm_rdata;
    logic [4:0]  m_a3;
    logic [1:0]  m_wdsel;
    logic [2:0]  m_ld_type;
    logic        grf_we, w_valid;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc, retire_cnt;
    logic        s_we, s_valid;
    logic [4:0]  s_a3;
    logic [31:0] s_wd, s_pc;
    logic [3:0]  s_cnt;

    int     nvec = 0, nerr = 0;
    longint exp_cnt = 0;
    instr_t cur, mw, bub;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .m_valid(m_valid),
        .m_pc(m_pc), .m_we(m_we), .m_a3(m_a3), .m_wdsel(m_wdsel), .m_alu(m_alu), .m_mdu(m_mdu),
        .m_dm_rdata(m_dm_rdata), .m_ld_type(m_ld_type), .grf_we(grf_we), .grf_a3(grf_a3),
        .grf_wd(grf_wd), .grf_pc(grf_pc), .w_valid(w_valid), .retire_cnt(retire_cnt)
    );
    wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .m_valid(m_valid),
        .m_pc(m_pc), .m_we(m_we), .m_a3(m_a3), .m_wdsel(m_wdsel), .m_alu(m_alu), .m_mdu(m_mdu),
        .m_dm_rdata(m_dm_rdata), .m_ld_type(m_ld_type), .grf_we(s_we), .grf_a3(s_a3),
        .grf_wd(s_wd), .grf_pc(s_pc), .w_valid(s_valid), .retire_cnt(s_cnt)
    );

    function automatic instr_t mk(logic v, logic [31:0] pc, logic we, logic [4:0] a3, logic [1:0] ws,
                                  logic [31:0] alu, logic [31:0] mdu, logic [31:0] rd, logic [2:0] ld);
        instr_t r;
        r.valid = v; r.pc = pc; r.we = we; r.a3 = a3; r.wdsel = ws;
        r.alu = alu; r.mdu = mdu; r.rdata = rd; r.ld = ld;
        return r;
    endfunction

    function automatic logic ref_we(instr_t i);
        return i.valid && i.we && i.a3 != 5'd0;
    endfunction

    // Architectural result of the instruction, from the ISA's load/link rules.
    function automatic logic [31:0] ref_wd(instr_t i);
        logic [31:0] v;
        if (!ref_we(i)) return 32'd0;
        if (i.wdsel == 2'd0) return i.alu;
        if (i.wdsel == 2'd2) return i.pc + 32'd8;
        if (i.wdsel == 2'd3) return i.mdu;
        if (i.ld == 3'd1 || i.ld == 3'd2) begin
            v = (i.rdata >> (i.alu[1] ? 16 : 0)) & 32'hFFFF;
            if (i.ld == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            return v;
        end
        if (i.ld == 3'd3 || i.ld == 3'd4) begin
            v = (i.rdata >> (8 * i.alu[1:0])) & 32'hFF;
            if (i.ld == 3'd3 && v >= 32'h80) v = v - 32'h100;
            return v;
        end
        return i.rdata;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        cur = i;
        m_valid = i.valid; m_pc = i.pc; m_we = i.we; m_a3 = i.a3; m_wdsel = i.wdsel;
        m_alu = i.alu; m_mdu = i.mdu; m_dm_rdata = i.rdata; m_ld_type = i.ld;
    endtask

    task automatic tick(input logic r, input logic s, input logic f);
        reset = r; stall_i = s; flush_i = f;
        if (r) exp_cnt = 0;
        else if (!s && mw.valid) exp_cnt++;
        if (r || f) mw = bub;
        else if (!s) mw = cur;
        @(posedge clk);
        #1;
        chk("grf_we", 32'(grf_we), 32'(ref_we(mw)));
        chk("grf_a3", 32'(grf_a3), ref_we(mw) ? 32'(mw.a3) : 32'd0);
        chk("grf_wd", grf_wd, ref_wd(mw));
        chk("grf_pc", grf_pc, mw.pc);
        chk("w_valid", 32'(w_valid), 32'(mw.valid));
        chk("retire_cnt", retire_cnt, 32'(exp_cnt));
        chk("retire_cnt4", 32'(s_cnt), 32'(exp_cnt % 16));
    endtask

    function automatic instr_t rnd();
        return mk($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 5'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)));
    endfunction

    vec_t tab[12];

    initial begin
        logic [31:0] held_wd, held_pc;
        bub = mk(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
        mw = bub;
        tab[0]  = '{mk(1, 32'h3000, 1, 8, 1, 32'h1003, 0, 32'h80123456, 3), 1, 8, 32'hFFFFFF80};
        tab[1]  = '{mk(1, 32'h3004, 1, 8, 1, 32'h1003, 0, 32'h80123456, 4), 1, 8, 32'h00000080};
        tab[2]  = '{mk(1, 32'h3008, 1, 9, 1, 32'h1002, 0, 32'h80123456, 1), 1, 9, 32'hFFFF8012};
        tab[3]  = '{mk(1, 32'h300C, 1, 9, 1, 32'h1001, 0, 32'h80123456, 2), 1, 9, 32'h00003456};
        tab[4]  = '{mk(1, 32'h3010, 1, 10, 1, 32'h1000, 0, 32'h80123456, 0), 1, 10, 32'h80123456};
        tab[5]  = '{mk(1, 32'h3014, 1, 0, 0, 32'h1234, 0, 0, 0), 0, 0, 32'h0};
        tab[6]  = '{mk(1, 32'h3010, 1, 31, 2, 0, 0, 0, 0), 1, 31, 32'h3018};
        tab[7]  = '{mk(1, 32'h3018, 1, 5, 3, 0, 32'hDEADBEEF, 0, 0), 1, 5, 32'hDEADBEEF};
        tab[8]  = '{mk(1, 32'h301C, 1, 6, 1, 32'h1001, 0, 32'h80123456, 3), 1, 6, 32'h00000034};
        tab[9]  = '{mk(1, 32'h3020, 1, 7, 1, 32'h1003, 0, 32'hCAFEF00D, 7), 1, 7, 32'hCAFEF00D};
        tab[10] = '{mk(0, 32'h3024, 1, 3, 0, 32'h55, 0, 0, 0), 0, 0, 32'h0};
        tab[11] = '{mk(1, 32'hFFFFFFFC, 1, 4, 2, 0, 0, 0, 0), 1, 4, 32'h4};

        drive(rnd());
        tick(1, 0, 0);
        tick(1, 1, 0);
        chk("reset_we", 32'(grf_we), 32'd0);
        chk("reset_a3", 32'(grf_a3), 32'd0);
        chk("reset_wd", grf_wd, 32'd0);
        chk("reset_pc", grf_pc, 32'h3000);
        chk("reset_cnt", retire_cnt, 32'd0);

        for (int k = 0; k < 12; k++) begin
            drive(tab[k].i);
            tick(0, 0, 0);
            chk($sformatf("tab%0d_we", k), 32'(grf_we), 32'(tab[k].we));
            chk($sformatf("tab%0d_a3", k), 32'(grf_a3), 32'(tab[k].a3));
            chk($sformatf("tab%0d_wd", k), grf_wd, tab[k].wd);
        end

        drive(mk(1, 32'h3010, 1, 31, 2, 0, 0, 0, 0));
        tick(0, 0, 0);
        held_wd = grf_wd;
        held_pc = retire_cnt;
        chk("jal_wd", grf_wd, 32'h3018);
        drive(rnd());
        for (int k = 0; k < 3; k++) tick(0, 1, 0);
        chk("stall_wd", grf_wd, 32'h3018);
        chk("stall_a3", 32'(grf_a3), 32'd31);
        chk("stall_cnt", retire_cnt, held_pc);

        drive(mk(1, 32'h4000, 1, 12, 0, 32'h77, 0, 0, 0));
        tick(0, 0, 1);
        chk("flush_valid", 32'(w_valid), 32'd0);
        chk("flush_we", 32'(grf_we), 32'd0);
        chk("flush_cnt", retire_cnt, held_pc + 32'd1);
        tick(0, 0, 0);
        tick(0, 1, 1);
        chk("flush_stall_valid", 32'(w_valid), 32'd0);
        chk("flush_stall_pc", grf_pc, 32'h3000);

        tick(0, 0, 0);
        tick(1, 1, 0);
        chk("reset_stall_valid", 32'(w_valid), 32'd0);
        chk("reset_stall_cnt", retire_cnt, 32'd0);

        for (int k = 0; k < 300; k++) begin
            drive(rnd());
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
        end

        tick(1, 0, 0);
        for (int k = 0; k < 18; k++) begin
            drive(mk(1, 32'h3000 + 32'(4 * k), 1, 2, 0, 32'(k), 0, 0, 0));
            tick(0, 0, 0);
        end
        chk("wrap_cnt4", 32'(s_cnt), 32'd1);
        chk("wrap_cnt32", retire_cnt, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (W) stage of the 5-stage pipelined MIPS core.
- Holds the M/W pipeline register, extends raw data-memory words for sub-word loads, and selects the write-back value.
- Drives the register file's write port (WE/A3/WD/pc) and exports the same triple for W→D/E forwarding.
- Keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_3000, value of the captured pc after reset and after a flush bubble.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hold W register contents (no capture)
- flush_i  in  1  load a bubble into W register
- m_valid  in  1  M-stage slot holds a real instruction
- m_pc  in  32  M-stage instruction pc
- m_we  in  1  instruction writes GRF
- m_a3  in  5  destination register
- m_wdsel  in  2  write-data source: 0 ALU, 1 MEM, 2 PC8, 3 MDU
- m_alu  in  32  ALU result (also the memory address)
- m_mdu  in  32  HI/LO read value
- m_dm_rdata  in  32  raw aligned word from data memory
- m_ld_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; others treated as LW
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- grf_pc  out  32  pc of instruction in W
- w_valid  out  1  W slot holds a real instruction
- retire_cnt  out  CNT_W  retired instructions since reset

Behaviour:
- Register capture on posedge clk:
  - Priority is reset > flush_i > stall_i > capture.
  - reset and flush both load a bubble: valid=0, we=0, a3=0, wdsel=0, all data fields 0, pc=RESET_PC.
  - Capture latches all m_* fields, plus m_alu[1:0] as addr_lo.
- Latency: one cycle from M inputs to GRF outputs. Outputs are combinational from the W register only; no direct path from m_* to outputs.
- grf_we = valid & we & (a3 != 0).
- grf_a3 = a3 when grf_we is 1, else 0.
- grf_wd = selected value when grf_we is 1, else 0. This keeps forwarding comparators safe against $0.
- Write-data selection:
  - ALU: alu.
  - MEM: load-extended rdata.
  - PC8: pc + 32'd8, modulo 2^32.
  - MDU: mdu.
- Load extension, MEM selection only:
  - LW: whole word.
  - LH/LHU: halfword rdata[16*addr_lo[1] +: 16]; addr_lo[0] ignored. Sign- or zero-extended.
  - LB/LBU: byte rdata[8*addr_lo +: 8]. Sign- or zero-extended.
- grf_pc = pc; w_valid = valid.
- retire_cnt:
  - Reset to 0.
  - +1 on each posedge where valid=1 and stall_i=0 and reset=0, i.e. the instruction leaves W. A flush in the same cycle still counts the departing instruction.
  - Wraps modulo 2^CNT_W.
- stall_i held for N cycles: outputs stable, grf_we may remain asserted (idempotent rewrite), counter frozen.
- Reset mid-stall: reset wins and the bubble is loaded.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: on each posedge where grf_we=1 and stall_i=0 and reset=0, print "@%h: $%d <= %h" with grf_pc, grf_a3, grf_wd. This matches the course judge trace format.
- Undefined: no simulation output; RTL otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - WDSEL_ALU/MEM/PC8/MDU (2-bit) and LD_LW/LH/LHU/LB/LBU (3-bit) constants.
  - RESET_PC default, shared with the fetch stage.
- One sub-module load_ext: combinational, inputs rdata[31:0], addr_lo[1:0], ld_type[2:0]; output ext[31:0].

Test Plan:
- Reset check: hold reset 2 cycles → grf_we=0, grf_a3=0, grf_wd=0, grf_pc=32'h3000, retire_cnt=0.
- LB with sign: m_wdsel=MEM, LB, m_alu=0x1003, rdata=0x80_12_34_56, a3=8 → next cycle grf_wd=0xFFFFFF80, grf_a3=8, grf_we=1. Repeat with LBU → 0x00000080; LH at alu=0x1002 → 0xFFFF8012.
- $0 write: we=1, a3=0, wdsel=ALU, alu=0x1234 → grf_we=0, grf_a3=0, grf_wd=0; retire_cnt still increments.
- Link write: jal at m_pc=0x3010, wdsel=PC8, a3=31 → grf_wd=0x3018. Then stall_i for 3 cycles → outputs unchanged, retire_cnt unchanged.
- Flush: flush_i=1 while m_valid=1 → next cycle w_valid=0, grf_we=0. Flush and stall together → bubble loaded (flush wins).
- Counter wrap: CNT_W=4, retire 17 valid instructions → retire_cnt=1.
